// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encoding, grant source and default burst bound shared by the arbiter files
package mem_port_arbiter_pkg;
  localparam int MAX_DM_BURST_DEF = 4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUSY = 3'd1,
    DM_BUSY = 3'd2,
    IF_DONE = 3'd3,
    DM_DONE = 3'd4
  } state_t;
  typedef enum logic {SRC_IF = 1'b0, SRC_DM = 1'b1} src_t;
endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter: counts data grants taken while a fetch waits, flags when fetch must win
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = MAX_DM_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  src_t src,
  input  logic if_req,
  output logic starve
);
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (grant) cnt <= (src == SRC_DM && if_req) ? (starve ? cnt : cnt + 4'd1) : 4'd0;
  assign starve = cnt == 4'(MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data ports, data first
// with a bounded burst so fetch always makes progress.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_DM_BURST = MAX_DM_BURST_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  state_t state, state_nx;
  logic starve, grant_if, grant_dm;
  assign grant_if = state == IDLE && if_req && (!dm_req || starve);
  assign grant_dm = state == IDLE && dm_req && !grant_if;
  arb_starve_counter #(.MAX(MAX_DM_BURST)) u_starve (
    .clk(CLK),
    .rst(RST),
    .grant(grant_if | grant_dm),
    .src(grant_dm ? SRC_DM : SRC_IF),
    .if_req(if_req),
    .starve(starve)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = grant_if ? IF_BUSY : grant_dm ? DM_BUSY : IDLE;
      IF_BUSY: state_nx = mem_ready ? IF_DONE : IF_BUSY;
      DM_BUSY: state_nx = mem_ready ? DM_DONE : DM_BUSY;
      default: state_nx = IDLE;
    endcase
  end
  // Memory side is fully registered; fields are latched once at grant and held until ready.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (grant_if || grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_dm && dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end else if (mem_req && mem_ready) mem_req <= 1'b0;
      if (state == IF_BUSY && mem_ready) if_rdata <= mem_rdata;
      if (state == DM_BUSY && mem_ready && !mem_we) dm_rdata <= mem_rdata;
    end
  assign if_valid = state == IF_DONE;
  assign dm_valid = state == DM_DONE;
  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus multi-cycle corner sequences against a wait-state memory model
module tb_mem_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_BURST(4)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: ready after wait_n extra cycles; idle cycles drive a decoy ready that must be ignored.
  int          wait_n = 0, busy_cyc = 0;
  logic [31:0] rdata_v = '0;
  logic        prev_req = 1'b0;
  logic [31:0] glog[$];
  always @(negedge CLK) begin
    if (mem_req && !prev_req) glog.push_back(mem_addr);
    prev_req = mem_req;
    if (!mem_req) begin
      busy_cyc  = 0;
      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
    end else begin
      mem_ready = busy_cyc == wait_n;
      mem_rdata = mem_ready ? rdata_v : 32'h0BAD_0BAD;
      busy_cyc++;
    end
  end

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } vec_t;
  vec_t vecs[6];
  logic [31:0] model_if = '0, model_dm = '0;

  task automatic run_vec(input vec_t v);
    int n, busy;
    bit done;
    n = 0; busy = 0; done = 0;
    wait_n = v.waits;
    rdata_v = v.rdata;
    @(negedge CLK);
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr; dm_we = 1'b1; dm_wdata = 32'h5555_AAAA;
    end
    while (!done && n < 64) begin
      @(negedge CLK);
      n++;
      if (v.dm ? dm_valid : if_valid) done = 1;
      else begin
        chk("stall_while_pending", {31'd0, v.dm ? dm_stall : if_stall}, 32'd1);
        if (mem_req) begin
          busy++;
          chk("mem_addr", mem_addr, v.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, v.dm & v.we});
          if (v.dm) chk("mem_wdata", mem_wdata, v.wdata);
        end
      end
    end
    chk("valid_seen", {31'd0, done}, 32'd1);
    chk("req_to_valid", n, v.waits + 2);
    chk("mem_req_cycles", busy, v.waits + 1);
    if (v.dm) begin
      if (!v.we) model_dm = v.rdata;
      chk("dm_rdata", dm_rdata, model_dm);
      chk("dm_stall_done", {31'd0, dm_stall}, 32'd0);
      dm_req = 1'b0;
    end else begin
      model_if = v.rdata;
      chk("if_rdata", if_rdata, model_if);
      chk("if_stall_done", {31'd0, if_stall}, 32'd0);
      if_req = 1'b0;
    end
    dm_we = 1'b0;
    @(negedge CLK);
    chk("valid_one_cycle", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("mem_req_after", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin : main
    int n, base, dcnt, pulses;
    bit is_if;
    bit exp_i[8];
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h2008_0005, 0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h00A0_0093, 2};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0108, 32'hCAFE_0001, 32'h0, 0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 5};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mem_ctl", {29'd0, mem_req, mem_we, if_valid | dm_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);

    // Reset lands in the middle of a long data read.
    wait_n = 10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
    repeat (3) @(negedge CLK);
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    chk("pre_rst_state", {29'd0, dut.state}, 32'd2);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("rst_mid_state", {29'd0, dut.state}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dm_req = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Simultaneous requests: data first, fetch next.
    base = glog.size();
    wait_n = 0;
    rdata_v = 32'h1111_2222;
    @(negedge CLK);
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      chk("sim_if_stall", {31'd0, if_stall}, 32'd1);
    end while (!dm_valid && n < 20);
    chk("sim_dm_valid", {31'd0, dm_valid}, 32'd1);
    chk("sim_dm_rdata", dm_rdata, 32'h1111_2222);
    dm_req = 1'b0;
    rdata_v = 32'h3333_4444;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!if_valid && n < 20);
    chk("sim_if_valid", {31'd0, if_valid}, 32'd1);
    chk("sim_if_rdata", if_rdata, 32'h3333_4444);
    if_req = 1'b0;
    @(negedge CLK);
    chk("sim_grants", glog.size() - base, 32'd2);
    chk("sim_first_dm", (base < glog.size()) ? glog[base] : 32'hX, 32'h200);
    chk("sim_then_if", (base + 1 < glog.size()) ? glog[base + 1] : 32'hX, 32'h40);

    // Starvation bound: fetch held while six data reads arrive back to back.
    base = glog.size();
    rdata_v = 32'h0000_0077;
    @(negedge CLK);
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_addr = 32'h300;
    dcnt = 0; n = 0;
    while (dcnt < 6 && n < 100) begin
      @(negedge CLK);
      n++;
      if (dm_valid) begin
        dcnt++;
        dm_addr = 32'h300 + 32'(4 * dcnt);
        if (dcnt == 6) dm_req = 1'b0;
      end
    end
    chk("starve_dm_done", dcnt, 32'd6);
    dm_req = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!if_valid && n < 20);
    chk("starve_final_if", {31'd0, if_valid}, 32'd1);
    if_req = 1'b0;
    @(negedge CLK);
    chk("starve_grants", glog.size() - base, 32'd8);
    for (int k = 0; k < 8; k++) begin
      is_if = (base + k < glog.size()) ? (glog[base + k] === 32'h40) : !exp_i[k];
      chk($sformatf("starve_order_%0d", k), {31'd0, is_if}, {31'd0, exp_i[k]});
    end

    // Fetch flushed while its memory access is in flight.
    base = glog.size();
    wait_n = 3;
    rdata_v = 32'h0000_0099;
    @(negedge CLK);
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge CLK);
    chk("flush_busy", {29'd0, dut.state}, 32'd1);
    if_req = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge CLK);
      if (if_valid) pulses++;
      chk("flush_no_stall", {31'd0, if_stall}, 32'd0);
    end
    chk("flush_pulses", pulses, 32'd1);
    chk("flush_grants", glog.size() - base, 32'd1);
    chk("flush_if_rdata", if_rdata, 32'h99);
    chk("flush_idle", {28'd0, dut.state, mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
